// File: rtl/machine_batch_dispatcher.sv
// Dispatches machine-configuration jobs onto NUM_WORKERS configure_machine engines and sums their results.
// Optional DISPATCH_ROUND_ROBIN_EN: rotating-pointer engine choice instead of lowest-index priority.
module machine_batch_dispatcher #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 13,
    parameter int MAX_NUM_LIGHTS_W  = $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
    parameter int NUM_WORKERS       = 4,
    parameter int SUM_W             = 32
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               job_valid,
    output logic                                               job_ready,
    input  logic                                               job_last,
    input  logic [MAX_NUM_LIGHTS_W-1:0]                        job_num_lights,
    input  logic [MAX_NUM_BUTTONS_W-1:0]                       job_num_buttons,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0]          job_buttons,
    input  logic [MAX_NUM_LIGHTS-1:0]                          job_target,
    output logic [NUM_WORKERS-1:0]                             wk_start,
    output logic [NUM_WORKERS*MAX_NUM_LIGHTS_W-1:0]            wk_num_lights,
    output logic [NUM_WORKERS*MAX_NUM_BUTTONS_W-1:0]           wk_num_buttons,
    output logic [NUM_WORKERS*MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] wk_buttons,
    output logic [NUM_WORKERS*MAX_NUM_LIGHTS-1:0]              wk_target,
    input  logic [NUM_WORKERS-1:0]                             wk_ready,
    input  logic [NUM_WORKERS*MAX_NUM_BUTTONS_W-1:0]           wk_presses,
    output logic                                               batch_done,
    output logic [SUM_W-1:0]                                   total_presses,
    output logic [SUM_W-1:0]                                   unsolvable_count,
    output logic [SUM_W-1:0]                                   jobs_accepted
);
    localparam int LW = MAX_NUM_LIGHTS_W;
    localparam int BW = MAX_NUM_BUTTONS_W;
    localparam int MW = MAX_NUM_BUTTONS * MAX_NUM_LIGHTS;
    localparam int L  = MAX_NUM_LIGHTS;
    localparam int PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [NUM_WORKERS-1:0]    busy_q, busy_d, start_q, start_d;
    logic [NUM_WORKERS-1:0]    free, done_vec, sel_oh;
    logic [NUM_WORKERS*LW-1:0] nl_q, nl_d;
    logic [NUM_WORKERS*BW-1:0] nb_q, nb_d;
    logic [NUM_WORKERS*MW-1:0] btn_q, btn_d;
    logic [NUM_WORKERS*L-1:0]  tgt_q, tgt_d;
    logic [SUM_W-1:0]          total_q, total_d, unsolv_q, unsolv_d, jobs_q, jobs_d;
    logic [SUM_W-1:0]          add_sum, add_unsolv;
    logic                      accept, first_accept;

    assign free         = ~busy_q;
    assign done_vec     = wk_ready & busy_q;
    assign job_ready    = ((state_q == S_IDLE) || (state_q == S_RUN)) && (|free);
    assign accept       = job_valid && job_ready;
    assign first_accept = accept && (state_q == S_IDLE);

`ifdef DISPATCH_ROUND_ROBIN_EN
    logic [PW-1:0] ptr_q, ptr_d;
    logic          rr_found;
    int            rr_idx;

    always_comb begin
        sel_oh   = '0;
        ptr_d    = ptr_q;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_WORKERS;
            if (!rr_found && free[rr_idx]) begin
                rr_found       = 1'b1;
                sel_oh[rr_idx] = 1'b1;
                if (accept) ptr_d = PW'((rr_idx + 1) % NUM_WORKERS);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    // Isolate the lowest set bit of the free mask.
    assign sel_oh = free & (~free + NUM_WORKERS'(1));
`endif

    always_comb begin
        busy_d  = (busy_q & ~done_vec) | (accept ? sel_oh : '0);
        start_d = accept ? sel_oh : '0;
        nl_d    = nl_q;
        nb_d    = nb_q;
        btn_d   = btn_q;
        tgt_d   = tgt_q;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (accept && sel_oh[i]) begin
                nl_d[i*LW +: LW]  = job_num_lights;
                nb_d[i*BW +: BW]  = job_num_buttons;
                btn_d[i*MW +: MW] = job_buttons;
                tgt_d[i*L +: L]   = job_target;
            end
        end

        // All-ones press count means the engine found no solution.
        add_sum    = '0;
        add_unsolv = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (done_vec[i]) begin
                if (wk_presses[i*BW +: BW] == {BW{1'b1}}) add_unsolv = add_unsolv + SUM_W'(1);
                else add_sum = add_sum + SUM_W'(wk_presses[i*BW +: BW]);
            end
        end
        total_d  = (first_accept ? '0 : total_q) + add_sum;
        unsolv_d = (first_accept ? '0 : unsolv_q) + add_unsolv;
        jobs_d   = (first_accept ? '0 : jobs_q) + SUM_W'(accept);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = job_last ? S_DRAIN : S_RUN;
            S_RUN:   if (accept && job_last) state_d = S_DRAIN;
            S_DRAIN: if ((busy_q == '0) && (wk_ready == '0)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= '0;
            start_q  <= '0;
            nl_q     <= '0;
            nb_q     <= '0;
            btn_q    <= '0;
            tgt_q    <= '0;
            total_q  <= '0;
            unsolv_q <= '0;
            jobs_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            nl_q     <= nl_d;
            nb_q     <= nb_d;
            btn_q    <= btn_d;
            tgt_q    <= tgt_d;
            total_q  <= total_d;
            unsolv_q <= unsolv_d;
            jobs_q   <= jobs_d;
        end
    end

    assign wk_start         = start_q;
    assign wk_num_lights    = nl_q;
    assign wk_num_buttons   = nb_q;
    assign wk_buttons       = btn_q;
    assign wk_target        = tgt_q;
    assign batch_done       = (state_q == S_DONE);
    assign total_presses    = total_q;
    assign unsolvable_count = unsolv_q;
    assign jobs_accepted    = jobs_q;
endmodule
